// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   state_t        : controller FSM encoding
//   seg_t          : segment vector, index 0 = a ... index 6 = g
//   SEG_LUT        : active-high glyphs for hex digits 0..F
//   SEG_DASH/BLANK : overflow glyph and all-off glyph
//   bcd_acc_width  : BCD accumulator width for a given digit count
package seven_seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  typedef logic [0:6] seg_t;

  localparam seg_t SEG_DASH  = 7'b0000001;
  localparam seg_t SEG_BLANK = 7'b0000000;

  // Written a..g left to right, so the leftmost bit lands on index 0 (a).
  localparam seg_t SEG_LUT [16] = '{
    7'b1111110,  // 0
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011,  // 4
    7'b1011011,  // 5
    7'b1011111,  // 6
    7'b1110000,  // 7
    7'b1111111,  // 8
    7'b1111011,  // 9
    7'b1110111,  // A
    7'b0011111,  // b
    7'b1001110,  // C
    7'b0111101,  // d
    7'b1001111,  // E
    7'b1000111   // F
  };

  // One spare nibble above the displayable digits catches values that do
  // not fit.
  function automatic int bcd_acc_width(input int num_digits);
    return 4 * num_digits + 4;
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per cycle).
//   clk, rst : clock, synchronous active-high reset
//   start    : load bin and begin DATA_W iterations
//   bin      : binary input, sampled with start
//   done     : high during the cycle whose closing edge performs the last
//              iteration; bcd/ovf are final from the next cycle on
//   bcd      : NUM_DIGITS BCD digits, digit 0 in the low nibble
//   ovf      : value does not fit NUM_DIGITS digits
import seven_seg_pkg::*;

module bin2bcd_seq #(
  parameter int DATA_W     = 16,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_W-1:0]       bin,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    ovf
);

  localparam int ACC_W = bcd_acc_width(NUM_DIGITS);
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] sr_q;
  logic [ACC_W-1:0]  acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_q;

  logic [ACC_W-1:0]  adj;
  logic [ACC_W-1:0]  shifted;
  logic              step_ovf;

  always_comb begin
    adj = acc_q;
    for (int i = 0; i < NUM_DIGITS + 1; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = {adj[ACC_W-2:0], sr_q[DATA_W-1]};
    // Sticky: a bit leaving the accumulator or any digit landing in the
    // spare nibble means the value cannot be shown.
    step_ovf = adj[ACC_W-1] | (|shifted[ACC_W-1 -: 4]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (start) begin
      sr_q  <= bin;
      acc_q <= '0;
      cnt_q <= CNT_W'(DATA_W);
      ovf_q <= 1'b0;
    end else if (cnt_q != '0) begin
      sr_q  <= sr_q << 1;
      acc_q <= shifted;
      cnt_q <= cnt_q - CNT_W'(1);
      ovf_q <= ovf_q | step_ovf;
    end
  end

  assign done = (cnt_q == CNT_W'(1));
  assign bcd  = acc_q[4*NUM_DIGITS-1:0];
  assign ovf  = ovf_q;

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multi-digit seven-segment controller: captures a value, converts it to
// BCD (or takes raw hex nibbles), commits it atomically to a display
// register and time-multiplexes the digits onto the board pins.
//   clk, rst  : clock, synchronous active-high reset
//   value     : binary value, captured with load
//   load      : one-cycle capture request, ignored while busy
//   hex_mode  : 1 = hex digits, 0 = decimal (sampled with load)
//   blank_lz  : blank leading zeros (sampled with load)
//   busy      : conversion/commit in progress
//   ovf       : displayed value does not fit NUM_DIGITS
//   SSeg      : segments a..g, SSeg[0] = a
//   an        : anode selects, an[0] = least-significant digit
//
// state  | meaning
// IDLE   | waiting for load
// CONV   | DATA_W shift-add-3 iterations in bin2bcd_seq
// COMMIT | write display register, blank flag and ovf together
import seven_seg_pkg::*;

module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS     = 4,
  parameter int DATA_W         = 16,
  parameter int DIV_COUNT      = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     value,
  input  logic                  load,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  ovf,
  output logic [0:6]            SSeg,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int DISP_W = 4 * NUM_DIGITS;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W  = $clog2(DIV_COUNT);

  localparam seg_t SEG_RST = (SEG_ACTIVE_LOW != 0) ? ~SEG_LUT[0] : SEG_LUT[0];
  localparam logic [NUM_DIGITS-1:0] AN_RST =
    (AN_ACTIVE_LOW != 0) ? ~NUM_DIGITS'(1) : NUM_DIGITS'(1);

  state_t state_q, state_d;
  logic   commit;
  logic   accept;

  logic [DATA_W-1:0] value_q;
  logic              hex_q;
  logic              blank_req_q;

  logic              conv_done;
  logic [DISP_W-1:0] conv_bcd;
  logic              conv_ovf;
  logic [DISP_W-1:0] hex_digits;
  logic              hex_ovf;

  logic [DISP_W-1:0] disp_q, disp_d;
  logic              ovf_q, ovf_d;
  logic              blank_q, blank_d;

  logic [DIV_W-1:0]  div_q, div_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              div_wrap;

  seg_t                  sseg_q;
  seg_t                  pat_d;
  logic [NUM_DIGITS-1:0] an_q;
  logic [NUM_DIGITS-1:0] onehot_d;

  assign accept = (state_q == ST_IDLE) && load;

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) state_d = hex_mode ? ST_COMMIT : ST_CONV;
      end
      ST_CONV: begin
        if (conv_done) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        commit  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      value_q     <= '0;
      hex_q       <= 1'b0;
      blank_req_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        value_q     <= value;
        hex_q       <= hex_mode;
        blank_req_q <= blank_lz;
      end
    end
  end

  bin2bcd_seq #(
    .DATA_W     (DATA_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (accept && !hex_mode),
    .bin   (value),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf)
  );

  generate
    if (DATA_W > DISP_W) begin : g_hex_wide
      assign hex_digits = value_q[DISP_W-1:0];
      assign hex_ovf    = |value_q[DATA_W-1:DISP_W];
    end else if (DATA_W == DISP_W) begin : g_hex_exact
      assign hex_digits = value_q;
      assign hex_ovf    = 1'b0;
    end else begin : g_hex_narrow
      assign hex_digits = {{(DISP_W - DATA_W){1'b0}}, value_q};
      assign hex_ovf    = 1'b0;
    end
  endgenerate

  always_comb begin
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    blank_d = blank_q;
    if (commit) begin
      disp_d  = hex_q ? hex_digits : conv_bcd;
      ovf_d   = hex_q ? hex_ovf : conv_ovf;
      blank_d = blank_req_q;
    end
  end

  // Free-running refresh divider and digit index.
  always_comb begin
    div_wrap = (div_q == DIV_W'(DIV_COUNT - 1));
    div_d    = div_wrap ? '0 : div_q + DIV_W'(1);
    idx_d    = idx_q;
    if (div_wrap) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  function automatic seg_t digit_pattern(input logic [DISP_W-1:0] disp,
                                         input logic [IDX_W-1:0]  idx,
                                         input logic              ovf_f,
                                         input logic              blank_f);
    logic       nz_above;
    logic [3:0] nib;
    nib      = disp[4*int'(idx) +: 4];
    nz_above = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx) && disp[4*i +: 4] != 4'd0) nz_above = 1'b1;
    end
    if (ovf_f)                                  return SEG_DASH;
    else if (blank_f && idx != '0 && !nz_above) return SEG_BLANK;
    else                                        return SEG_LUT[nib];
  endfunction

  // SSeg and an are decoded from next-state values so both registers
  // switch on the same edge as the display register and the digit index.
  always_comb begin
    pat_d    = digit_pattern(disp_d, idx_d, ovf_d, blank_d);
    onehot_d = NUM_DIGITS'(1) << idx_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      blank_q <= 1'b0;
      div_q   <= '0;
      idx_q   <= '0;
      sseg_q  <= SEG_RST;
      an_q    <= AN_RST;
    end else begin
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      blank_q <= blank_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      sseg_q  <= (SEG_ACTIVE_LOW != 0) ? ~pat_d : pat_d;
      an_q    <= (AN_ACTIVE_LOW != 0) ? ~onehot_d : onehot_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign ovf  = ovf_q;
  assign SSeg = sseg_q;
  assign an   = an_q;

endmodule
